// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: executes decoder loads/stores as single word-wide
// req/gnt/rvalid bus accesses and holds the pipeline until each one retires.
//
// state | meaning
// IDLE  | nothing in flight; decode, check and launch new accesses
// REQ   | bus_req asserted with latched address/enables/data, waiting for bus_gnt
// WAIT  | read granted, waiting for bus_rvalid
// DONE  | one-cycle retire: rvalid or fault pulse; decoder request ignored
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] FC_ILLEGAL = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUS_ERR = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    localparam logic [CW:0] TIMEOUT_V = (CW+1)'(TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lane_q, lane_d;
    logic [2:0]    f3_q, f3_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          fault_q, fault_d;
    logic [1:0]    fault_code_q, fault_code_d;

    logic          access;
    logic          load_ok;
    logic          store_ok;
    logic          illegal;
    logic          misaligned;
    logic          accept;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [CW:0]   cnt_inc;
    logic          timeout_hit;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (f3[1:0])
            2'b00:   extend_load = f3[2] ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   extend_load = f3[2] ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: extend_load = shifted;
        endcase
    endfunction

    always_comb begin
        access   = memread | memwrite;
        load_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_ok = funct3 inside {3'b000, 3'b001, 3'b010};
        illegal  = (memread & memwrite) | (memread & ~load_ok) | (memwrite & ~store_ok);

        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase

        accept = (state_q == IDLE) & access & ~illegal & ~misaligned;

        cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_V);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        lane_d       = lane_q;
        f3_d         = f3_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        fault_d      = 1'b1;
                        fault_code_d = FC_ILLEGAL;
                    end else if (misaligned) begin
                        fault_d      = 1'b1;
                        fault_code_d = FC_MISALIGN;
                    end else begin
                        state_d     = REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = memwrite;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                        lane_d      = addr[1:0];
                        f3_d        = funct3;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_inc[CW-1:0];
                // A completing write grant wins over a timeout on the same cycle; a read
                // grant does not complete the access, so the timeout takes precedence.
                if (bus_gnt && bus_we_q) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (bus_err) begin
                        fault_d      = 1'b1;
                        fault_code_d = FC_BUS_ERR;
                    end
                end else if (timeout_hit) begin
                    state_d      = DONE;
                    bus_req_d    = 1'b0;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                end else if (bus_gnt) begin
                    state_d   = WAIT;
                    bus_req_d = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc[CW-1:0];
                if (bus_rvalid) begin
                    state_d = DONE;
                    if (bus_err) begin
                        fault_d      = 1'b1;
                        fault_code_d = FC_BUS_ERR;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = extend_load(bus_rdata, lane_q, f3_q);
                    end
                end else if (timeout_hit) begin
                    state_d      = DONE;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lane_q       <= 2'b00;
            f3_q         <= 3'b000;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_be_q     <= 4'h0;
            bus_wdata_q  <= 32'h0;
            rdata_q      <= 32'h0;
            rvalid_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            f3_q         <= f3_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    // The launching cycle must stall before anything is registered.
    assign stall      = accept | (state_q == REQ) | (state_q == WAIT);
    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: a driver models each access from the
// load/store rules, a bus responder plays the slave, and a monitor checks responses.
module tb_lsu_bus_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;
    logic [1:0]  fault_code;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_err = 1'b0;

    lsu_bus_ctrl #(.TIMEOUT(T), .CW(8)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rvalid(rvalid), .fault(fault), .fault_code(fault_code),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_fault;
        logic [1:0]  code;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Bus responder configuration, written by the driver for each access.
    int          s_g = 0;
    int          s_r = 0;
    bit          s_err = 1'b0;
    bit          s_we = 1'b0;
    logic [31:0] s_data = 32'h0;
    int          s_seq = 0;
    bit          spurious = 1'b0;
    int          s_seen = 0;
    int          s_req_cnt = 0;
    int          s_wait_cnt = 0;
    bit          s_in_wait = 1'b0;

    always @(negedge clk) begin
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        bus_rdata  = $urandom;
        if (s_seq != s_seen) begin
            s_seen     = s_seq;
            s_req_cnt  = 0;
            s_wait_cnt = 0;
            s_in_wait  = 1'b0;
        end
        if (spurious) begin
            bus_gnt    = 1'b1;
            bus_rvalid = 1'b1;
        end else if (bus_req) begin
            if (s_req_cnt == s_g) begin
                bus_gnt   = 1'b1;
                bus_err   = s_err && s_we;
                s_in_wait = !s_we;
            end else begin
                bus_rvalid = 1'($urandom_range(0, 1));
            end
            s_req_cnt++;
        end else if (s_in_wait) begin
            if (s_wait_cnt == s_r) begin
                bus_rvalid = 1'b1;
                bus_err    = s_err;
                bus_rdata  = s_data;
                s_in_wait  = 1'b0;
            end else begin
                bus_gnt = 1'($urandom_range(0, 1));
                s_wait_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (rvalid || fault)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", {30'h0, rvalid, fault}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                if (mon_e.is_fault) begin
                    chk("fault", 32'(fault), 32'd1);
                    chk("fault_code", 32'(fault_code), 32'(mon_e.code));
                    chk("rvalid_on_fault", 32'(rvalid), 32'd0);
                end else begin
                    chk("rvalid", 32'(rvalid), 32'd1);
                    chk("rdata", rdata, mon_e.data);
                    chk("fault_on_load", 32'(fault), 32'd0);
                end
            end
        end
    end

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int g, input int r, input bit err, input logic [31:0] data);
        int          idx;
        int          n;
        int          s_cyc;
        int          req_cyc;
        bit          is_b, is_h, is_w, illegal, mis;
        logic [31:0] exp_be, exp_wd, v;
        rsp_t        e;

        idx     = int'(a[1:0]);
        is_b    = (f3 == 3'd0) || (f3 == 3'd4);
        is_h    = (f3 == 3'd1) || (f3 == 3'd5);
        is_w    = (f3 == 3'd2);
        illegal = (rd && wr) || (rd && !(is_b || is_h || is_w)) || (wr && !(f3 <= 3'd2));
        mis     = (is_h && (idx % 2) != 0) || (is_w && idx != 0);
        exp_be  = is_b ? (32'd1 << idx) : is_h ? (32'd3 << idx) : 32'd15;
        exp_wd  = is_b ? (wd & 32'hFF) * 32'h01010101
                : is_h ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        v = data >> (8 * idx);
        if (is_b) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (is_h) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
        end

        memread  = rd;
        memwrite = wr;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        s_g      = g;
        s_r      = r;
        s_err    = err;
        s_we     = wr;
        s_data   = data;
        s_seq++;

        s_cyc      = 0;
        req_cyc    = 0;
        e.is_fault = 1'b0;
        e.code     = 2'd0;
        e.data     = 32'h0;
        e.due      = cyc + 1;
        if (rd || wr) begin
            if (illegal || mis) begin
                e.is_fault = 1'b1;
                e.code     = illegal ? 2'd0 : 2'd1;
                exp_q.push_back(e);
            end else begin
                n       = (g + 1) + (rd ? r + 1 : 0);
                req_cyc = (T != 0 && g + 1 > T) ? T : g + 1;
                if (T != 0 && n > T) begin
                    s_cyc      = 1 + T;
                    e.is_fault = 1'b1;
                    e.code     = 2'd3;
                end else begin
                    s_cyc = 1 + n;
                    if (err) begin
                        e.is_fault = 1'b1;
                        e.code     = 2'd2;
                    end else begin
                        e.data = v;
                    end
                end
                e.due = cyc + s_cyc;
                if (e.is_fault || rd) exp_q.push_back(e);
            end
        end

        for (int k = 0; k <= s_cyc; k++) begin
            @(negedge clk);
            chk("stall", 32'(stall), (k < s_cyc) ? 32'd1 : 32'd0);
            chk("bus_req", 32'(bus_req), (k >= 1 && k <= req_cyc) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= req_cyc) begin
                chk("bus_addr", bus_addr, a & 32'hFFFFFFFC);
                chk("bus_be", 32'(bus_be), exp_be);
                chk("bus_we", 32'(bus_we), 32'(wr));
                if (wr) chk("bus_wdata", bus_wdata, exp_wd);
            end
            @(posedge clk);
            #1;
        end
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    initial begin
        bit          rd, wr, er;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        @(posedge clk);
        #1;

        //      rd    wr    f3      addr          wdata         g    r  err   bus data
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0,        0,   0, 1'b0, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0,        0,   0, 1'b0, 32'h80112233);
        run_op(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0,        0,   0, 1'b0, 32'h80112233);
        run_op(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0,        0,   0, 1'b0, 32'h80112233);
        run_op(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234ABCD, 3,   0, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0,        0,   0, 1'b0, 32'h0);
        run_op(1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h5,        0,   0, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0500, 32'h0,        100, 0, 1'b0, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'h0,        0,   1, 1'b1, 32'h12345678);
        run_op(1'b0, 1'b1, 3'd4, 32'h0000_0300, 32'h77,       0,   0, 1'b0, 32'h0);
        run_op(1'b0, 1'b1, 3'd2, 32'h0000_0600, 32'hCAFEF00D, 1,   0, 1'b1, 32'h0);
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_0106, 32'h0,        2,   1, 1'b0, 32'h0000FFFE);

        // Stray grants and read data while idle must be ignored.
        spurious = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_stall", 32'(stall), 32'd0);
            chk("spurious_bus_req", 32'(bus_req), 32'd0);
            @(posedge clk);
            #1;
        end
        spurious = 1'b0;

        // Reset while a load sits in WAIT; its rvalid arrives after the reset.
        memread = 1'b1;
        funct3  = 3'd2;
        addr    = 32'h0000_0700;
        s_g     = 0;
        s_r     = 1;
        s_err   = 1'b0;
        s_we    = 1'b0;
        s_data  = 32'hA5A5A5A5;
        s_seq++;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        reset   = 1'b1;
        memread = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_stall", 32'(stall), 32'd0);
            chk("post_rst_bus_req", 32'(bus_req), 32'd0);
            chk("post_rst_rvalid", 32'(rvalid), 32'd0);
            chk("post_rst_fault", 32'(fault), 32'd0);
            @(posedge clk);
            #1;
        end
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0800, 32'h0, 0, 0, 1'b0, 32'h0BADCAFE);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 19));
            rd  = (sel < 9) || (sel == 18);
            wr  = (sel >= 9 && sel < 17) || (sel == 18);
            f3  = 3'($urandom_range(0, 7));
            if ((f3 == 3'd3 || f3 > 3'd5) && $urandom_range(0, 3) != 0) f3 = 3'd2;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                else if (f3[1:0] == 2'b01) a[0] = 1'b0;
            end
            er = ($urandom_range(0, 7) == 0);
            run_op(rd, wr, f3, a, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), er, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
